// File: rtl/vga_capture.sv
// VGA sink: rebuilds pixel coordinates from HSYNC/VSYNC/BLANK_N, emits framebuffer
// writes, and checks line/frame timing to report lock status.
module vga_capture #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_TOTAL  = 525
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        VGA_HSYNC,
    input  logic        VGA_VSYNC,
    input  logic        VGA_BLANK_N,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    output logic        wr_en,
    output logic [9:0]  wr_x,
    output logic [8:0]  wr_y,
    output logic [23:0] wr_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        locked,
    output logic        line_err,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);
    localparam logic [10:0] HT = 11'(H_TOTAL);
    localparam logic [9:0]  HA = 10'(H_ACTIVE);
    localparam logic [8:0]  VA = 9'(V_ACTIVE);
    localparam logic [9:0]  VT = 10'(V_TOTAL);

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;
    state_t state, state_next;

    logic        hs1, vs1, bl1, hs_prev, vs_prev;
    logic [23:0] rgb1;
    logic [10:0] hclk;
    logic [9:0]  px_cnt, lines_in_frame;
    logic [8:0]  act_lines;
    logic        err_seen, hchk;

    logic        hfall, vfall, line_bad, frame_bad;
    logic        frame_err_now, frame_done_now, pix, wr_now;
    logic [9:0]  px_base, lines_after;
    logic [8:0]  act_after, act_base;

    // Line close is folded in before frame close so a shared edge counts its own line.
    always_comb begin
        hfall    = hs_prev & ~hs1;
        vfall    = vs_prev & ~vs1;
        line_bad = hfall && ((hchk && hclk != HT) || (px_cnt != '0 && px_cnt != HA));

        act_after = act_lines;
        if (hfall && px_cnt != '0 && act_lines != '1)
            act_after = act_lines + 9'd1;
        lines_after = lines_in_frame;
        if (hfall && lines_in_frame != '1)
            lines_after = lines_in_frame + 10'd1;

        frame_bad      = (lines_after != VT) || (act_after != VA) || err_seen || line_bad;
        frame_err_now  = vfall && (state != UNLOCKED) && frame_bad;
        frame_done_now = vfall && (state == LOCKED) && !frame_bad;

        px_base  = hfall ? '0 : px_cnt;
        act_base = vfall ? '0 : act_after;
        pix      = bl1 && (state != UNLOCKED);
        wr_now   = pix && (px_base < HA) && (act_base < VA);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            UNLOCKED: if (vfall) state_next = ACQUIRE;
            ACQUIRE:  if (vfall && !frame_bad) state_next = LOCKED;
            LOCKED:   if (line_bad || frame_err_now) state_next = ACQUIRE;
            default:  state_next = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs1            <= 1'b1;
            vs1            <= 1'b1;
            bl1            <= 1'b0;
            rgb1           <= '0;
            hs_prev        <= 1'b1;
            vs_prev        <= 1'b1;
            state          <= UNLOCKED;
            hclk           <= '0;
            hchk           <= 1'b0;
            px_cnt         <= '0;
            act_lines      <= '0;
            lines_in_frame <= '0;
            err_seen       <= 1'b0;
            wr_en          <= 1'b0;
            wr_x           <= '0;
            wr_y           <= '0;
            wr_data        <= '0;
            frame_start    <= 1'b0;
            frame_done     <= 1'b0;
            line_err       <= 1'b0;
            frame_err      <= 1'b0;
            locked         <= 1'b0;
            frame_cnt      <= '0;
        end else begin
            hs1     <= VGA_HSYNC;
            vs1     <= VGA_VSYNC;
            bl1     <= VGA_BLANK_N;
            rgb1    <= {vga_r, vga_g, vga_b};
            hs_prev <= hs1;
            vs_prev <= vs1;
            state   <= state_next;

            // hclk restarts at 1 so it equals the fall-to-fall period at the next fall.
            if (hfall) begin
                hclk <= 11'd1;
                hchk <= 1'b1;
            end else if (hclk != '1) begin
                hclk <= hclk + 11'd1;
            end

            if (pix && px_base != '1)
                px_cnt <= px_base + 10'd1;
            else
                px_cnt <= px_base;

            if (vfall) begin
                act_lines      <= '0;
                lines_in_frame <= '0;
                err_seen       <= 1'b0;
            end else begin
                act_lines      <= act_after;
                lines_in_frame <= lines_after;
                err_seen       <= err_seen | line_bad;
            end

            wr_en <= wr_now;
            if (wr_now) begin
                wr_x    <= px_base;
                wr_y    <= act_base;
                wr_data <= rgb1;
            end

            frame_start <= vfall;
            frame_done  <= frame_done_now;
            line_err    <= line_bad;
            frame_err   <= frame_err_now;
            locked      <= (state_next == LOCKED);
            if (frame_done_now)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end
endmodule
